// File: rtl/stopwatch_button_ctrl_if.sv
// Button, count and display signals between the stopwatch control stage and its surroundings.
// Master drives buttons/count and observes the controls; slave is the control stage itself.
interface stopwatch_button_ctrl_if;
  logic        btn_ss;
  logic        btn_lap;
  logic [15:0] count_in;
  logic        stop_go;
  logic        clr;
  logic [15:0] disp_out;
  logic        lap_active;
  logic [1:0]  state;

  modport master (
    output btn_ss, btn_lap, count_in,
    input  stop_go, clr, disp_out, lap_active, state
  );

  modport slave (
    input  btn_ss, btn_lap, count_in,
    output stop_go, clr, disp_out, lap_active, state
  );
endinterface

// File: rtl/stopwatch_button_ctrl.sv
// Debounces start/stop and lap/clear buttons and runs the IDLE/RUN/LAP/STOP stopwatch FSM.
// A stable press changes state on the 6th S_clk edge; clr is a one-cycle registered pulse.
module stopwatch_button_ctrl #(
  parameter int DEB_CNT    = 3,
  parameter int LONG_PRESS = 100
) (
  input  logic S_clk,
  input  logic reset,
  stopwatch_button_ctrl_if.slave sw
);
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int HW = $clog2(LONG_PRESS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  // Index 0 = start/stop, index 1 = lap/clear
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_deb;
  logic [1:0]    r_deb_q;
  logic [DW-1:0] r_deb_cnt [2];
  logic [HW-1:0] r_hold;
  logic          r_long_fired;
  state_t        r_state;
  logic          r_clr;
  logic [15:0]   r_lap_reg;

  logic w_ss_press;
  logic w_lap_long;
  logic w_lap_short;
  logic w_btn [2];

  assign w_btn[0] = sw.btn_ss;
  assign w_btn[1] = sw.btn_lap;

  always_ff @(posedge S_clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_deb_q <= r_deb;
      for (int i = 0; i < 2; i++) begin
        r_sync1[i] <= w_btn[i];
        r_sync2[i] <= r_sync1[i];
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DW'(DEB_CNT - 1)) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Long press latches r_long_fired so the eventual release is not also a short press
  always_ff @(posedge S_clk or posedge reset) begin
    if (reset) begin
      r_hold       <= '0;
      r_long_fired <= 1'b0;
    end else if (!r_deb[1]) begin
      r_hold       <= '0;
      r_long_fired <= 1'b0;
    end else begin
      if (r_hold != HW'(LONG_PRESS)) r_hold <= r_hold + 1'b1;
      if (w_lap_long) r_long_fired <= 1'b1;
    end
  end

  assign w_ss_press  = r_deb[0] & ~r_deb_q[0];
  assign w_lap_long  = r_deb[1] & (r_hold == HW'(LONG_PRESS)) & ~r_long_fired;
  assign w_lap_short = ~r_deb[1] & r_deb_q[1] & ~r_long_fired;

  always_ff @(posedge S_clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_clr     <= 1'b0;
      r_lap_reg <= '0;
    end else begin
      r_clr <= 1'b0;
      if (w_lap_long) begin
        if (r_state != IDLE) begin
          r_state <= IDLE;
          r_clr   <= 1'b1;
        end
      end else if (w_ss_press) begin
        case (r_state)
          IDLE:    r_state <= RUN;
          RUN:     r_state <= STOP;
          LAP:     r_state <= STOP;
          default: r_state <= RUN;
        endcase
      end else if (w_lap_short) begin
        case (r_state)
          RUN: begin
            r_state   <= LAP;
            r_lap_reg <= sw.count_in;
          end
          LAP:  r_state <= RUN;
          STOP: begin
            r_state <= IDLE;
            r_clr   <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign sw.state      = r_state;
  assign sw.stop_go    = (r_state == IDLE) || (r_state == STOP);
  assign sw.lap_active = (r_state == LAP);
  assign sw.clr        = r_clr;
  assign sw.disp_out   = (r_state == LAP) ? r_lap_reg : sw.count_in;
endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// Directed bench for stopwatch_button_ctrl: debounce timing, FSM transitions, lap freeze, clr pulse, async reset.
module tb_stopwatch_button_ctrl;
  logic S_clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   clr_cnt;
  int   clr_first;

  stopwatch_button_ctrl_if sw ();

  stopwatch_button_ctrl #(.DEB_CNT(3), .LONG_PRESS(100)) dut (
    .S_clk (S_clk),
    .reset (reset),
    .sw    (sw.slave)
  );

  initial begin
    S_clk = 1'b0;
    forever #5 S_clk = ~S_clk;
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge S_clk);
      #1;
    end
  endtask

  task automatic press_ss();
    sw.btn_ss = 1'b1;
    tick(8);
    sw.btn_ss = 1'b0;
    tick(8);
  endtask

  task automatic press_lap();
    sw.btn_lap = 1'b1;
    tick(8);
    sw.btn_lap = 1'b0;
    tick(8);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    sw.btn_ss   = 1'b0;
    sw.btn_lap  = 1'b0;
    sw.count_in = 16'h0042;
    #12 reset = 1'b0;

    // 1: reset state and start/stop latency
    check("rst_state", 16'(sw.state), 16'h0);
    check("rst_stop_go", 16'(sw.stop_go), 16'h1);
    check("rst_clr", 16'(sw.clr), 16'h0);
    check("rst_lap_active", 16'(sw.lap_active), 16'h0);
    check("rst_disp", sw.disp_out, 16'h0042);
    sw.btn_ss = 1'b1;
    tick(5);
    check("t1_edge5_state", 16'(sw.state), 16'h0);
    check("t1_edge5_stop_go", 16'(sw.stop_go), 16'h1);
    tick(1);
    check("t1_edge6_state", 16'(sw.state), 16'h1);
    check("t1_edge6_stop_go", 16'(sw.stop_go), 16'h0);
    tick(4);
    sw.btn_ss = 1'b0;
    tick(10);
    check("t1_release_state", 16'(sw.state), 16'h1);

    // 2: bouncing start/stop never debounces
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sw.btn_ss = ~sw.btn_ss;
      tick(1);
    end
    sw.btn_ss = 1'b0;
    tick(10);
    check("t2_state", 16'(sw.state), 16'h0);
    check("t2_stop_go", 16'(sw.stop_go), 16'h1);

    // 3: lap freezes the display while the count keeps running
    do_reset();
    press_ss();
    check("t3_run", 16'(sw.state), 16'h1);
    sw.count_in = 16'h0123;
    press_lap();
    check("t3_lap_state", 16'(sw.state), 16'h2);
    check("t3_lap_active", 16'(sw.lap_active), 16'h1);
    check("t3_lap_stop_go", 16'(sw.stop_go), 16'h0);
    sw.count_in = 16'h0150;
    tick(1);
    check("t3_frozen_disp", sw.disp_out, 16'h0123);
    press_lap();
    check("t3_back_run", 16'(sw.state), 16'h1);
    check("t3_lap_active_off", 16'(sw.lap_active), 16'h0);
    check("t3_live_disp", sw.disp_out, 16'h0150);

    // 4: STOP + lap short clears with a single clr cycle
    press_ss();
    check("t4_stop", 16'(sw.state), 16'h3);
    sw.count_in = 16'h0512;
    sw.btn_lap = 1'b1;
    tick(8);
    sw.btn_lap = 1'b0;
    clr_cnt = 0;
    clr_first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (sw.clr && clr_first == 0) clr_first = i;
      if (sw.clr) clr_cnt++;
    end
    check("t4_clr_count", 16'(clr_cnt), 16'd1);
    check("t4_clr_edge", 16'(clr_first), 16'd6);
    check("t4_state", 16'(sw.state), 16'h0);
    check("t4_stop_go", 16'(sw.stop_go), 16'h1);
    check("t4_disp", sw.disp_out, 16'h0512);

    // 5: long lap hold from RUN clears once; release adds nothing
    press_ss();
    check("t5_run", 16'(sw.state), 16'h1);
    clr_cnt = 0;
    clr_first = 0;
    sw.btn_lap = 1'b1;
    for (int i = 1; i <= 150; i++) begin
      tick(1);
      if (sw.clr && clr_first == 0) clr_first = i;
      if (sw.clr) clr_cnt++;
    end
    sw.btn_lap = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (sw.clr) clr_cnt++;
    end
    check("t5_clr_count", 16'(clr_cnt), 16'd1);
    check("t5_clr_edge", 16'(clr_first), 16'd106);
    check("t5_state", 16'(sw.state), 16'h0);

    // 6: async reset in LAP with start/stop half-debounced, then re-debounce
    press_ss();
    press_lap();
    check("t6_lap", 16'(sw.state), 16'h2);
    sw.btn_ss = 1'b1;
    tick(3);
    #2 reset = 1'b1;
    #1;
    check("t6_state", 16'(sw.state), 16'h0);
    check("t6_stop_go", 16'(sw.stop_go), 16'h1);
    check("t6_lap_active", 16'(sw.lap_active), 16'h0);
    check("t6_clr", 16'(sw.clr), 16'h0);
    #1 reset = 1'b0;
    tick(5);
    check("t6_redeb_edge5", 16'(sw.state), 16'h0);
    tick(1);
    check("t6_redeb_edge6", 16'(sw.state), 16'h1);
    sw.btn_ss = 1'b0;
    tick(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
